// File: rtl/tlut_pkg.sv
// rtl/tlut_pkg.sv - shared types and defaults for the TLUT result drain stage
package tlut_pkg;

  localparam int DIM_MULT_DEF  = 9;
  localparam int ACC_WIDTH_DEF = 8;
  localparam int OUT_WIDTH_DEF = 16;
  localparam int BEAT_W_DEF    = 8;
  localparam int LANE_W_DEF    = (DIM_MULT_DEF > 1) ? $clog2(DIM_MULT_DEF) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } drain_state_t;

  typedef logic [LANE_W_DEF-1:0] lane_idx_t;

endpackage

// File: rtl/tlut_sat_acc_lane.sv
// rtl/tlut_sat_acc_lane.sv - one saturating K-reduction accumulator lane
module tlut_sat_acc_lane #(
  parameter int ACC_WIDTH = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_add,
  input  logic                 i_clear,
  input  logic [ACC_WIDTH-1:0] i_data,
  output logic [OUT_WIDTH-1:0] o_acc,
  output logic                 o_sat
);

  logic [OUT_WIDTH-1:0] r_acc;
  logic [OUT_WIDTH:0]   w_sum;
  logic                 w_carry;

  // One extra bit of headroom makes the carry out the saturation indicator
  assign w_sum   = (OUT_WIDTH+1)'(r_acc) + (OUT_WIDTH+1)'(i_data);
  assign w_carry = w_sum[OUT_WIDTH];
  assign o_sat   = i_add & w_carry;
  assign o_acc   = r_acc;

  // Accumulator register: clear wins, then load (first beat), then saturating add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= OUT_WIDTH'(i_data);
    end else if (i_add) begin
      r_acc <= w_carry ? {OUT_WIDTH{1'b1}} : w_sum[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/tlut_result_drain.sv
// rtl/tlut_result_drain.sv - K-beat lane reduction with serial valid/ready drain
module tlut_result_drain
  import tlut_pkg::*;
#(
  parameter int  DIM_MULT  = DIM_MULT_DEF,
  parameter int  ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int  OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int  BEAT_W    = BEAT_W_DEF,
  localparam int LW        = (DIM_MULT > 1) ? $clog2(DIM_MULT) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  input  logic                                in_last,
  output logic                                in_ready,
  input  logic [DIM_MULT-1:0][ACC_WIDTH-1:0]  acc_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_WIDTH-1:0]                out_data,
  output logic [LW-1:0]                       out_lane,
  output logic                                out_last,
  output logic                                overflow,
  output logic [BEAT_W-1:0]                   beat_count,
  output logic                                busy
);

  drain_state_t         r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [LW-1:0]        r_out_lane;
  logic                 r_out_last;
  logic                 r_overflow;
  logic [BEAT_W-1:0]    r_beat_count;

  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_load;
  logic                 w_add;
  logic                 w_clear;
  logic                 w_any_sat;
  logic [DIM_MULT-1:0]  w_sat;
  logic [OUT_WIDTH-1:0] w_acc [DIM_MULT];

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_load     = (r_state == IDLE)  & w_in_fire;
  assign w_add      = (r_state == ACCUM) & w_in_fire;
  // Final lane leaving the stage wipes every accumulator for the next reduction
  assign w_clear    = w_out_fire & r_out_last;
  assign w_any_sat  = |w_sat;

  genvar g;
  generate
    for (g = 0; g < DIM_MULT; g++) begin : g_lane
      tlut_sat_acc_lane #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
      ) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_add   (w_add),
        .i_clear (w_clear),
        .i_data  (acc_in[g]),
        .o_acc   (w_acc[g]),
        .o_sat   (w_sat[g])
      );
    end
  endgenerate

  // Accumulators are frozen during DRAIN, so the lane mux output is stable under stall
  assign out_data   = w_acc[r_out_lane];
  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_lane   = r_out_lane;
  assign out_last   = r_out_last;
  assign overflow   = r_overflow;
  assign beat_count = r_beat_count;
  assign busy       = (r_state != IDLE);

  // Control FSM: accept beats in IDLE/ACCUM, then walk lanes out one per transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_lane   <= '0;
      r_out_last   <= 1'b0;
      r_overflow   <= 1'b0;
      r_beat_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_beat_count <= BEAT_W'(1);
            if (in_last) begin
              r_state     <= DRAIN;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_lane  <= '0;
              r_out_last  <= (DIM_MULT == 1);
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_in_fire) begin
            if (r_beat_count != {BEAT_W{1'b1}}) begin
              r_beat_count <= r_beat_count + BEAT_W'(1);
            end
            if (w_any_sat) begin
              r_overflow <= 1'b1;
            end
            if (in_last) begin
              r_state     <= DRAIN;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_lane  <= '0;
              r_out_last  <= (DIM_MULT == 1);
            end
          end
        end
        DRAIN: begin
          if (w_out_fire) begin
            if (r_out_last) begin
              r_state      <= IDLE;
              r_in_ready   <= 1'b1;
              r_out_valid  <= 1'b0;
              r_out_lane   <= '0;
              r_out_last   <= 1'b0;
              r_overflow   <= 1'b0;
              r_beat_count <= '0;
            end else begin
              r_out_lane <= r_out_lane + LW'(1);
              r_out_last <= ((r_out_lane + LW'(1)) == LW'(DIM_MULT - 1));
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlut_result_drain.sv
// tb/tb_tlut_result_drain.sv - randomized scoreboard bench for tlut_result_drain
module tb_tlut_result_drain;
  import tlut_pkg::*;

  localparam int DM   = 9;
  localparam int AW   = 8;
  localparam int OW   = 16;
  localparam int BW   = 8;
  localparam int LW   = $clog2(DM);
  localparam int OMAX = (1 << OW) - 1;
  localparam int BMAX = (1 << BW) - 1;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic [DM-1:0][AW-1:0]   acc_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [OW-1:0]           out_data;
  logic [LW-1:0]           out_lane;
  logic                    out_last;
  logic                    overflow;
  logic [BW-1:0]           beat_count;
  logic                    busy;

  tlut_result_drain #(
    .DIM_MULT  (DM),
    .ACC_WIDTH (AW),
    .OUT_WIDTH (OW),
    .BEAT_W    (BW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .acc_in     (acc_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_last   (out_last),
    .overflow   (overflow),
    .beat_count (beat_count),
    .busy       (busy)
  );

  typedef struct {
    int lane;
    int data;
    bit last;
    bit ovf;
    int bc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;
  int   rcnt = 0;

  // reference model state: per-lane sums of the reduction in progress
  int   sums[DM];
  int   mbeats;
  bit   movf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // consumer: always ready, a 1,0,0 pattern, or random
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1: begin out_ready = (rcnt % 3 == 0); rcnt++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: pops expected words on every transfer, checks stall hold and no bubbles
  initial begin
    logic      prev_v, prev_r, prev_last;
    logic [OW-1:0] prev_d;
    lane_idx_t prev_l;
    exp_t e;
    prev_v = 1'b0; prev_r = 1'b0; prev_last = 1'b0; prev_d = '0; prev_l = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (prev_v && !prev_r) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, prev_d);
          chk("hold_lane", out_lane, prev_l);
          chk("hold_last", out_last, prev_last);
        end
        if (prev_v && prev_r && !prev_last) chk("no_bubble", out_valid, 1);
        if (out_valid) chk("in_ready_drain", in_ready, 0);
        else if (busy) chk("in_ready_accum", in_ready, 1);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out actual=lane%0d required=no_output", out_lane);
          end else begin
            e = q.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_lane", out_lane, e.lane);
            chk("out_last", out_last, e.last);
            chk("overflow", overflow, e.ovf);
            chk("beat_count", beat_count, e.bc);
          end
        end
        prev_v = out_valid; prev_r = out_ready; prev_d = out_data;
        prev_l = out_lane;  prev_last = out_last;
      end
    end
  end

  // one reduction of k beats; kind: 0 i*i, 1 i, 2 all 255, 3 random, 4 all 3
  task automatic send_red(input int k, input int kind);
    int val, s, n;
    bit ok;
    for (int b = 0; b < k; b++) begin
      if (b > 0 && kind == 3 && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      for (int i = 0; i < DM; i++) begin
        case (kind)
          0:       val = i * i;
          1:       val = i;
          2:       val = 255;
          3:       val = $urandom_range(0, 255);
          default: val = 3;
        endcase
        acc_in[i] = AW'(val);
      end
      in_last  = (b == k - 1);
      in_valid = 1'b1;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 300) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        n++;
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL beat_accept_timeout actual=%0d required=<300", n);
      end
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int i = 0; i < DM; i++) begin
        if (b == 0) begin
          sums[i] = int'(acc_in[i]);
        end else begin
          s = sums[i] + int'(acc_in[i]);
          if (s > OMAX) begin s = OMAX; movf = 1'b1; end
          sums[i] = s;
        end
      end
      if (b == 0) begin
        mbeats = 1;
        movf   = 1'b0;
      end else if (mbeats < BMAX) begin
        mbeats++;
      end
      if (b == k - 1) begin
        for (int i = 0; i < DM; i++) begin
          q.push_back('{lane: i, data: sums[i], last: (i == DM - 1), ovf: movf, bc: mbeats});
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", (n < 3000), 1);
    chk("idle_overflow_clear", overflow, 0);
    chk("idle_beat_count_clear", beat_count, 0);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; acc_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_lane", out_lane, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_beat_count", beat_count, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    ready_mode = 0;
    send_red(1, 0);            // K=1, squares
    wait_idle();
    send_red(4, 1);            // K=4, lane index
    wait_idle();
    send_red(258, 2);          // saturates every lane and beat_count
    wait_idle();

    ready_mode = 1;            // backpressure plus back-to-back reductions
    send_red(3, 3);
    send_red(2, 3);
    wait_idle();

    ready_mode = 2;
    for (int r = 0; r < 6; r++) send_red($urandom_range(1, 6), 3);
    wait_idle();

    ready_mode = 0;            // reset in the middle of a drain
    send_red(2, 3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_lane == LW'(4)) && n < 100);
    chk("lane4_reached", (n < 100), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_lane", out_lane, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_beat_count", beat_count, 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_red(1, 4);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
